seg_scan_ctrl: RTL

//  Multiplexed 7-segment scan controller. Sits directly upstream of the hex-to-segment decoder.

---
 rtl/seg_scan_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller; optional LEADING_ZERO_BLANK_EN darkens leading zero digits.
// Latency: outputs registered, update on the same edge as the slot index; loads show at the next frame wrap.
// Backpressure: none; load is a strobe, and a later load before commit overwrites the shadow copy.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEAD       = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc, presc_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] disp_val, disp_val_nxt, shadow_val;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_nxt, shadow_dp;
  logic                    tick, wrap, commit, blank, dark, dp_sel;
  logic [3:0]              dig_sel;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [NUM_DIGITS:0]     zero_from;

  always_comb begin
    tick         = (presc == PRESC_LAST);
    wrap         = tick && (idx == IDX_LAST);
    commit       = wrap && pending;
    presc_nxt    = tick ? '0 : presc + 1'b1;
    idx_nxt      = idx;
    if (tick) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    disp_val_nxt = commit ? shadow_val : disp_val;
    disp_dp_nxt  = commit ? shadow_dp  : disp_dp;
    blank        = (presc_nxt < DEAD);

    // zero_from[k]: digits k..top of the value about to be shown are all zero
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--)
      zero_from[k] = zero_from[k+1] && (disp_val_nxt[4*k +: 4] == 4'h0);

    dig_sel = 4'h0;
    dp_sel  = 1'b0;
    dark    = 1'b0;
    an_lit  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        dig_sel   = disp_val_nxt[4*i +: 4];
        dp_sel    = disp_dp_nxt[i];
        an_lit[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        dark      = (i != 0) && zero_from[i] && !disp_dp_nxt[i];
`else
        dark      = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      digit_out   <= 4'h0;
      an_n        <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      disp_val    <= disp_val_nxt;
      disp_dp     <= disp_dp_nxt;
      // a load on the wrap edge lands after the commit, so it waits a frame
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (commit) begin
        pending    <= 1'b0;
      end
      digit_out   <= dig_sel;
      an_n        <= (blank || dark) ? '1 : an_lit;
      dp_n        <= (blank || dark) ? 1'b1 : ~dp_sel;
      frame_start <= wrap;
    end
  end

endmodule
